// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the buffered UART register block:
// register offsets, STAT/CTRL bit positions and FSM encodings.
package uart_mmio_pkg;

    localparam logic [1:0] REG_STAT  = 2'd0;
    localparam logic [1:0] REG_DATA  = 2'd1;
    localparam logic [1:0] REG_CTRL  = 2'd2;
    localparam logic [1:0] REG_LEVEL = 2'd3;

    localparam int STAT_RX_NE    = 0;
    localparam int STAT_TX_NF    = 1;
    localparam int STAT_RX_FULL  = 3;
    localparam int STAT_TX_EMPTY = 4;
    localparam int STAT_TX_OVR   = 5;
    localparam int STAT_RX_OVR   = 6;
    localparam int STAT_IRQ      = 7;

    localparam int CTRL_RXIE  = 0;
    localparam int CTRL_TXIE  = 1;
    localparam int CTRL_FLUSH = 7;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_e;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/uart_fifo_mmio_sync_fifo.sv
// Single-clock FIFO with flush; push and pop may share a cycle,
// and a push into a full FIFO is only accepted alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~flush & ~empty;
    assign do_push = push & ~flush & (~full | do_pop);

    // Pointer/count next state; flush overrides any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)
                count_d = count_q + 1'b1;
            else if (!do_push && do_pop)
                count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents behind the pointers need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_fifo_mmio.sv
// Buffered UART register block: RX/TX FIFOs between the CPU bus
// and the uart_rx/uart_tx byte engines, with a level interrupt.
module uart_fifo_mmio
    import uart_mmio_pkg::*;
#(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] sel,
    input  logic       rd_stb,
    input  logic       wr_stb,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_ready,
    output logic       rx_clear,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_ready
);

    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);

    rx_state_e  rx_state_q, rx_state_d;
    tx_state_e  tx_state_q, tx_state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       rxie_q, rxie_d;
    logic       txie_q, txie_d;
    logic       rx_ovr_q, rx_ovr_d;
    logic       tx_ovr_q, tx_ovr_d;
    logic       irq_n_q;

    logic         rx_push, rx_pop, rx_full, rx_empty;
    logic         tx_push, tx_pop, tx_full, tx_empty;
    logic [RAW:0] rx_count;
    logic [TAW:0] tx_count;
    logic [7:0]   rx_head, tx_head;
    logic         wr_stat, wr_data, wr_ctrl, rd_data;
    logic         flush, irq_pend;

    assign wr_stat = wr_stb & (sel == REG_STAT);
    assign wr_data = wr_stb & (sel == REG_DATA);
    assign wr_ctrl = wr_stb & (sel == REG_CTRL);
    assign rd_data = rd_stb & (sel == REG_DATA);
    assign flush   = wr_ctrl & wdata[CTRL_FLUSH];
    assign rx_pop  = rd_data & ~rx_empty;
    assign tx_push = wr_data;

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_push),
        .pop     (rx_pop),
        .flush   (flush),
        .din     (rx_data),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count),
        .head    (rx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tx_push),
        .pop     (tx_pop),
        .flush   (flush),
        .din     (wdata),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count),
        .head    (tx_head)
    );

    // RX handshake: take one byte per rx_data_ready pulse.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_push    = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_data_ready) begin
                    rx_push    = 1'b1;
                    rx_state_d = RX_ACK;
                end
            end
            RX_ACK: begin
                if (!rx_data_ready) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // TX handshake: launch the head byte when the engine is ready.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty && tx_ready && !flush) begin
                    tx_pop     = 1'b1;
                    tx_data_d  = tx_head;
                    tx_state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                if (!tx_ready) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Control bits and sticky overflow flags; flush clears last.
    always_comb begin
        rxie_d   = rxie_q;
        txie_d   = txie_q;
        rx_ovr_d = rx_ovr_q;
        tx_ovr_d = tx_ovr_q;
        if (wr_ctrl) begin
            rxie_d = wdata[CTRL_RXIE];
            txie_d = wdata[CTRL_TXIE];
        end
        if (rx_push && rx_full && !rx_pop) rx_ovr_d = 1'b1;
        if (tx_push && tx_full && !tx_pop) tx_ovr_d = 1'b1;
        if (wr_stat && wdata[STAT_RX_OVR]) rx_ovr_d = 1'b0;
        if (wr_stat && wdata[STAT_TX_OVR]) tx_ovr_d = 1'b0;
        if (flush) begin
            rx_ovr_d = 1'b0;
            tx_ovr_d = 1'b0;
        end
    end

    assign irq_pend = (rxie_q & ~rx_empty)
                    | (txie_q & tx_empty & (tx_state_q == TX_IDLE));

    // State, control and interrupt registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q <= RX_IDLE;
            tx_state_q <= TX_IDLE;
            tx_data_q  <= '0;
            rxie_q     <= 1'b0;
            txie_q     <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_ovr_q   <= 1'b0;
            irq_n_q    <= 1'b1;
        end else begin
            rx_state_q <= rx_state_d;
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
            rxie_q     <= rxie_d;
            txie_q     <= txie_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_ovr_q   <= tx_ovr_d;
            irq_n_q    <= ~irq_pend;
        end
    end

    // Read mux; DATA shows 0x00 rather than stale storage when empty.
    always_comb begin
        rdata = '0;
        unique case (sel)
            REG_STAT: begin
                rdata[STAT_IRQ]      = irq_pend;
                rdata[STAT_RX_OVR]   = rx_ovr_q;
                rdata[STAT_TX_OVR]   = tx_ovr_q;
                rdata[STAT_TX_EMPTY] = tx_empty;
                rdata[STAT_RX_FULL]  = rx_full;
                rdata[STAT_TX_NF]    = ~tx_full;
                rdata[STAT_RX_NE]    = ~rx_empty;
            end
            REG_DATA: rdata = rx_empty ? 8'h00 : rx_head;
            REG_CTRL: begin
                rdata[CTRL_RXIE] = rxie_q;
                rdata[CTRL_TXIE] = txie_q;
            end
            REG_LEVEL: rdata = 8'(rx_count);
        endcase
    end

    assign rx_clear = (rx_state_q == RX_ACK);
    assign tx_send  = (tx_state_q == TX_SEND);
    assign tx_data  = tx_data_q;
    assign irq_n    = irq_n_q;

endmodule
